uart_rx: RTL and testbench

//   Even-parity UART receiver: the downstream consumer of the transmitter's serial TxD line.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper and default frame settings.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int BAUD_RATE_DEF  = 115_200;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  function automatic int cycles_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops reset to RESET_VAL.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Even-parity UART receiver: start, DATA_WIDTH data bits LSB-first, even parity, one stop bit,
// each sampled at mid-bit; emits a one-cycle rx_valid with parity and framing flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = BAUD_RATE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RxD,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CPB   = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  logic rxs;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  busy_q, busy_d;
  logic                  cnt_last;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (RxD),
    .q_o   (rxs)
  );

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: a line that has returned high was a glitch, not a start bit.
        if (cnt_q == CNT_HALF) begin
          if (rxs) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            idx_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          shreg_d[DATA_WIDTH-1] = rxs;
          if (idx_q == IDX_LAST) state_d = RX_PARITY;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (cnt_last) begin
          par_d   = rxs;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_last) begin
          valid_d = 1'b1;
          data_d  = shreg_q;
          perr_d  = ^{shreg_q, par_q};
          ferr_d  = ~rxs;
          state_d = rxs ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        // A line held low after a bad stop bit must not look like a fresh start edge.
        if (rxs) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign RxData     = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames with hand-computed flags plus hand-written
// sequences for glitch rejection, back-to-back frames and mid-frame reset.
module tb_uart_rx;

  // Line rate is raised so a frame is ~1.2k clocks; glitch timing below is scaled to match.
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 921_600;
  localparam int CPB      = 108;
  localparam int W        = 8;

  logic         clk;
  logic         reset;
  logic         RxD;
  logic [W-1:0] RxData;
  logic         rx_valid;
  logic         parity_err;
  logic         frame_err;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] got_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         stop_low;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .DATA_WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .RxData     (RxData),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected %0d checks to finish", n_total);
    $fatal(1, "watchdog");
  end

  // Every cycle rx_valid is high is logged, so a stretched strobe shows up as an extra word.
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back({RxData, parity_err, frame_err});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_bits(input logic v, input int nbits);
    RxD = v;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input int stop_low);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
    drive_bits(par, 1);
    if (stop_low == 0) drive_bits(1'b1, 1);
    else               drive_bits(1'b0, stop_low);
  endtask

  task automatic drain_check(input string tag);
    logic [W+1:0] g;
    logic [W+1:0] e;
    check({tag, " strobe count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " RxData"},     g[W+1:2], e[W+1:2]);
      check({tag, " parity_err"}, g[1],     e[1]);
      check({tag, " frame_err"},  g[0],     e[0]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 0, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 3, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 0, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 1'b0, 0, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
    vecs[7] = '{8'h6E, 1'b1, 0, 1'b0, 1'b0};

    reset = 1'b1;
    RxD   = 1'b1;
    repeat (5) @(negedge clk);
    check("reset RxData",     RxData,     0);
    check("reset rx_valid",   rx_valid,   0);
    check("reset parity_err", parity_err, 0);
    check("reset frame_err",  frame_err,  0);
    check("reset busy",       busy,       0);
    reset = 1'b0;
    drive_bits(1'b1, 2);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back({vecs[v].data, vecs[v].exp_perr, vecs[v].exp_ferr});
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop_low);
      if (vecs[v].stop_low > 0) check($sformatf("vec%0d busy in break", v), busy, 1);
      drive_bits(1'b1, 2);
      check($sformatf("vec%0d busy idle", v), busy, 0);
      drain_check($sformatf("vec%0d", v));
    end

    // Short low glitch: false start, no strobe
    RxD = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch busy high", busy, 1);
    repeat (15) @(negedge clk);
    RxD = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch busy low", busy, 0);
    drain_check("glitch");

    // Back-to-back frames with no idle gap
    exp_q.push_back({8'h00, 1'b0, 1'b0});
    exp_q.push_back({8'hFF, 1'b0, 1'b0});
    exp_q.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(8'h00, 1'b0, 0);
    send_frame(8'hFF, 1'b0, 0);
    send_frame(8'h5A, 1'b0, 0);
    drive_bits(1'b1, 2);
    drain_check("b2b");

    // Reset in the middle of data bit 3 of 0x77
    drive_bits(1'b0, 1);
    for (int i = 0; i < 3; i++) drive_bits(1'b1, 1);
    RxD = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    check("pre-reset busy", busy, 1);
    reset = 1'b1;
    RxD   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset RxData",     RxData,     0);
    check("midreset rx_valid",   rx_valid,   0);
    check("midreset parity_err", parity_err, 0);
    check("midreset frame_err",  frame_err,  0);
    check("midreset busy",       busy,       0);
    drive_bits(1'b1, 12);
    drain_check("midreset");

    exp_q.push_back({8'h12, 1'b0, 1'b0});
    send_frame(8'h12, 1'b0, 0);
    drive_bits(1'b1, 2);
    check("post-reset busy", busy, 0);
    drain_check("post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
